// File: rtl/des_key_sched_ctrl_if.sv
// DES key schedule sequencer bundle: key load request, key_shift
// loop signals and the subkey valid/ready stream.
interface des_key_sched_ctrl_if;
    logic [63:0] key_in;
    logic        key_load;
    logic        decrypt;
    logic        busy;
    logic [55:0] k56;
    logic [4:0]  rnd_sel;
    logic [55:0] k_shifted;
    logic [47:0] subkey;
    logic [4:0]  subkey_rnd;
    logic        subkey_valid;
    logic        subkey_ready;
    logic        key_done;

    modport master (
        output key_in, key_load, decrypt, k_shifted, subkey_ready,
        input  busy, k56, rnd_sel, subkey, subkey_rnd,
        input  subkey_valid, key_done
    );

    modport slave (
        input  key_in, key_load, decrypt, k_shifted, subkey_ready,
        output busy, k56, rnd_sel, subkey, subkey_rnd,
        output subkey_valid, key_done
    );
endinterface

// File: rtl/des_key_sched_ctrl.sv
// DES key schedule sequencer: PC-1 on load, walks key_shift through
// 16 rounds, streams PC-2 subkeys over valid/ready.
module des_key_sched_ctrl (
    input  logic                  clk,
    input  logic                  rst,
    des_key_sched_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    // Table entries are 1-based with bit 1 at the MSB.
    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] o;
        o = '0;
        for (int i = 0; i < 56; i++) begin
            o[6'(55 - i)] = k[6'(64 - PC1[i])];
        end
        return o;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] k);
        logic [47:0] o;
        o = '0;
        for (int i = 0; i < 48; i++) begin
            o[6'(47 - i)] = k[6'(56 - PC2[i])];
        end
        return o;
    endfunction

    state_t      state;
    state_t      state_d;
    logic        mode_q;
    logic [55:0] k56_q;
    logic [4:0]  rnd_q;
    logic [4:0]  rnd_nxt;
    logic [47:0] sk_q;
    logic [4:0]  skr_q;
    logic        vld_q;
    logic        done_q;
    logic        busy;
    logic        slot_free;
    logic        xfer;
    logic        last;

    assign slot_free = !vld_q || bus.subkey_ready;
    assign xfer      = vld_q && bus.subkey_ready;
    assign last      = mode_q ? (rnd_q == 5'd1) : (rnd_q == 5'd16);

    // Round stepping: ascending for encrypt, descending for decrypt.
    always_comb begin
        rnd_nxt = rnd_q;
        if (last) begin
            rnd_nxt = 5'd0;
        end else if (mode_q) begin
            rnd_nxt = rnd_q - 5'd1;
        end else begin
            rnd_nxt = rnd_q + 5'd1;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:    if (bus.key_load)        state_d = RUN;
            RUN:     if (slot_free && last)   state_d = DRAIN;
            DRAIN:   if (xfer)                state_d = IDLE;
            default:                          state_d = IDLE;
        endcase
    end

    // Output decode of state.
    always_comb begin
        busy = (state != IDLE);
    end

    // Key, round counter and subkey output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= 1'b0;
            k56_q  <= '0;
            rnd_q  <= '0;
            sk_q   <= '0;
            skr_q  <= '0;
            vld_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.key_load) begin
                        k56_q  <= pc1(bus.key_in);
                        mode_q <= bus.decrypt;
                        rnd_q  <= bus.decrypt ? 5'd16 : 5'd1;
                    end
                end
                RUN: begin
                    if (slot_free) begin
                        sk_q  <= pc2(bus.k_shifted);
                        skr_q <= rnd_q;
                        vld_q <= 1'b1;
                        rnd_q <= rnd_nxt;
                    end
                end
                DRAIN: begin
                    if (xfer) begin
                        vld_q  <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    vld_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy         = busy;
    assign bus.k56          = k56_q;
    assign bus.rnd_sel      = rnd_q;
    assign bus.subkey       = sk_q;
    assign bus.subkey_rnd   = skr_q;
    assign bus.subkey_valid = vld_q;
    assign bus.key_done     = done_q;
endmodule

// File: tb/tb_des_key_sched_ctrl.sv
// Self-checking bench for des_key_sched_ctrl with a behavioural
// key_shift in the loop and a FIPS 46-3 subkey reference model.
module tb_des_key_sched_ctrl;
    logic clk;
    logic rst;

    des_key_sched_ctrl_if bus ();

    des_key_sched_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int pc1_t [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    int pc2_t [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    function automatic logic [55:0] pc1_m(input logic [63:0] k);
        logic [55:0] o;
        o = '0;
        for (int i = 1; i <= 56; i++) o[56 - i] = k[64 - pc1_t[i - 1]];
        return o;
    endfunction

    function automatic logic [47:0] pc2_m(input logic [55:0] k);
        logic [47:0] o;
        o = '0;
        for (int i = 1; i <= 48; i++) o[48 - i] = k[56 - pc2_t[i - 1]];
        return o;
    endfunction

    // key_shift: C and D halves rotated left by the cumulative
    // shift count of rounds 1..r (round 0 = unshifted).
    function automatic logic [55:0] ks_m(input logic [55:0] k, input logic [4:0] r);
        int s;
        logic [27:0] c;
        logic [27:0] d;
        s = 0;
        for (int i = 1; i <= 16; i++) begin
            if (i <= int'(r)) s += (i == 1 || i == 2 || i == 9 || i == 16) ? 1 : 2;
        end
        c = k[55:28];
        d = k[27:0];
        c = (c << s) | (c >> (28 - s));
        d = (d << s) | (d >> (28 - s));
        return {c, d};
    endfunction

    function automatic logic [47:0] exp_sub(input logic [63:0] key, input int r);
        return pc2_m(ks_m(pc1_m(key), 5'(r)));
    endfunction

    assign bus.k_shifted = ks_m(bus.k56, bus.rnd_sel);

    int n_assert = 0;
    int n_fail   = 0;

    logic [4:0]  xr [$];
    logic [47:0] xk [$];
    int          n_done;
    int          n_win;
    int          n_hold;
    int          first_at;
    int          done_at;
    bit          t_out;
    logic [55:0] k56_seen;

    localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;

    // Loads a key and collects one whole schedule. Cycle 0 is the
    // first negedge after the edge that sampled key_load.
    task automatic run_sched(input logic [63:0] key, input bit dec,
                             input int pct, input int stall_rnd,
                             input int stall_n, input bit poke);
        logic [47:0] p_sk;
        logic [4:0]  p_rnd;
        bit          p_st;
        bit          rdy;
        bit          fin;
        int          stalled;
        xr.delete();
        xk.delete();
        n_done = 0; n_win = 0; n_hold = 0;
        first_at = -1; done_at = -1; t_out = 0;
        p_st = 0; fin = 0; stalled = 0;
        p_sk = '0; p_rnd = '0;
        @(negedge clk);
        bus.key_in = key;
        bus.decrypt = dec;
        bus.key_load = 1'b1;
        bus.subkey_ready = 1'b0;
        @(negedge clk);
        bus.key_load = 1'b0;
        bus.key_in = {$urandom, $urandom};
        k56_seen = bus.k56;
        for (int c = 0; c < 300 && !fin; c++) begin
            if (p_st && (!bus.subkey_valid || bus.subkey !== p_sk ||
                         bus.subkey_rnd !== p_rnd)) n_hold++;
            if (bus.key_done) begin
                n_done++;
                if (done_at < 0) done_at = c;
            end
            if (bus.subkey_valid) begin
                n_win++;
                if (first_at < 0) first_at = c;
            end
            if (!bus.busy) begin
                fin = 1;
            end else begin
                rdy = ($urandom_range(1, 100) <= pct);
                if (bus.subkey_valid && int'(bus.subkey_rnd) == stall_rnd &&
                    stalled < stall_n) begin
                    rdy = 1'b0;
                    stalled++;
                end
                bus.subkey_ready = rdy;
                bus.key_load = poke && (c == 6);
                if (poke && c == 6) begin
                    bus.key_in = ~key;
                    bus.decrypt = ~dec;
                end
                if (bus.subkey_valid && rdy) begin
                    xr.push_back(bus.subkey_rnd);
                    xk.push_back(bus.subkey);
                end
                p_st = bus.subkey_valid && !rdy;
                p_sk = bus.subkey;
                p_rnd = bus.subkey_rnd;
                @(negedge clk);
            end
        end
        if (!fin) t_out = 1;
        bus.subkey_ready = 1'b0;
        bus.key_load = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus.key_done) n_done++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        @(negedge clk);
        n_assert++;
        if ({bus.k56, bus.rnd_sel, bus.subkey, bus.subkey_rnd,
             bus.subkey_valid, bus.key_done, bus.busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got k56=%h rnd=%0d sk=%h skr=%0d v=%b d=%b busy=%b, want all 0",
                     bus.k56, bus.rnd_sel, bus.subkey, bus.subkey_rnd,
                     bus.subkey_valid, bus.key_done, bus.busy);
        end
        rst = 1'b0;
        @(negedge clk);
        n_assert++;
        if (bus.busy !== 1'b0 || bus.rnd_sel !== 5'd0) begin
            n_fail++;
            $display("FAIL idle_after_reset: busy=%b rnd=%0d, want 0 0", bus.busy, bus.rnd_sel);
        end
    endtask

    task automatic test_encrypt_vector;
        run_sched(KEY_A, 1'b0, 100, -1, 0, 1'b0);
        n_assert++;
        if (t_out) begin n_fail++; $display("FAIL enc_timeout: schedule did not finish"); end
        n_assert++;
        if (k56_seen !== 56'hF0CCAAF556678F) begin
            n_fail++;
            $display("FAIL enc_k56: got %h want F0CCAAF556678F", k56_seen);
        end
        n_assert++;
        if (first_at !== 1) begin
            n_fail++;
            $display("FAIL enc_first_valid: got cycle %0d want 1", first_at);
        end
        n_assert++;
        if (xk.size() != 16) begin
            n_fail++;
            $display("FAIL enc_count: got %0d want 16", xk.size());
        end else begin
            n_assert++;
            if (xk[0] !== 48'h1B02EFFC7072) begin
                n_fail++;
                $display("FAIL enc_round1: got %h want 1B02EFFC7072", xk[0]);
            end
            n_assert++;
            if (xk[15] !== 48'hCB3D8B0E17F5) begin
                n_fail++;
                $display("FAIL enc_round16: got %h want CB3D8B0E17F5", xk[15]);
            end
            for (int i = 0; i < 16; i++) begin
                n_assert++;
                if (xr[i] !== 5'(i + 1) || xk[i] !== exp_sub(KEY_A, i + 1)) begin
                    n_fail++;
                    $display("FAIL enc_sub[%0d]: got rnd %0d %h want rnd %0d %h",
                             i, xr[i], xk[i], i + 1, exp_sub(KEY_A, i + 1));
                end
            end
        end
        n_assert++;
        if (done_at !== 17 || n_done !== 1 || n_win !== 16) begin
            n_fail++;
            $display("FAIL enc_done: got at %0d cnt %0d win %0d want 17 1 16",
                     done_at, n_done, n_win);
        end
    endtask

    task automatic test_decrypt_vector;
        run_sched(KEY_A, 1'b1, 100, -1, 0, 1'b0);
        n_assert++;
        if (t_out || xk.size() != 16) begin
            n_fail++;
            $display("FAIL dec_count: got %0d timeout %b want 16 0", xk.size(), t_out);
        end else begin
            n_assert++;
            if (xk[0] !== 48'hCB3D8B0E17F5 || xk[15] !== 48'h1B02EFFC7072) begin
                n_fail++;
                $display("FAIL dec_ends: got %h %h want CB3D8B0E17F5 1B02EFFC7072", xk[0], xk[15]);
            end
            for (int i = 0; i < 16; i++) begin
                n_assert++;
                if (xr[i] !== 5'(16 - i) || xk[i] !== exp_sub(KEY_A, 16 - i)) begin
                    n_fail++;
                    $display("FAIL dec_sub[%0d]: got rnd %0d %h want rnd %0d %h",
                             i, xr[i], xk[i], 16 - i, exp_sub(KEY_A, 16 - i));
                end
            end
        end
        n_assert++;
        if (n_done !== 1) begin
            n_fail++;
            $display("FAIL dec_done: got %0d pulses want 1", n_done);
        end
    endtask

    task automatic test_backpressure;
        logic [63:0] key;
        key = {$urandom, $urandom};
        run_sched(key, 1'b0, 100, 5, 3, 1'b0);
        n_assert++;
        if (n_hold !== 0) begin
            n_fail++;
            $display("FAIL bp_hold: got %0d unstable stall cycles want 0", n_hold);
        end
        n_assert++;
        if (n_win !== 19 || xk.size() != 16 || n_done !== 1) begin
            n_fail++;
            $display("FAIL bp_window: got win %0d xfers %0d done %0d want 19 16 1",
                     n_win, xk.size(), n_done);
        end
        for (int i = 0; i < xk.size(); i++) begin
            n_assert++;
            if (xr[i] !== 5'(i + 1) || xk[i] !== exp_sub(key, i + 1)) begin
                n_fail++;
                $display("FAIL bp_sub[%0d]: got rnd %0d %h want rnd %0d %h",
                         i, xr[i], xk[i], i + 1, exp_sub(key, i + 1));
            end
        end
    endtask

    task automatic test_load_ignored;
        logic [63:0] key;
        key = {$urandom, $urandom};
        run_sched(key, 1'b0, 100, -1, 0, 1'b1);
        n_assert++;
        if (xk.size() != 16 || n_done !== 1) begin
            n_fail++;
            $display("FAIL poke_count: got %0d xfers %0d done want 16 1", xk.size(), n_done);
        end
        for (int i = 0; i < xk.size(); i++) begin
            n_assert++;
            if (xr[i] !== 5'(i + 1) || xk[i] !== exp_sub(key, i + 1)) begin
                n_fail++;
                $display("FAIL poke_sub[%0d]: got rnd %0d %h want rnd %0d %h",
                         i, xr[i], xk[i], i + 1, exp_sub(key, i + 1));
            end
        end
    endtask

    task automatic test_reset_mid;
        bit hit;
        int dn;
        hit = 0;
        dn = 0;
        @(negedge clk);
        bus.key_in = KEY_A;
        bus.decrypt = 1'b0;
        bus.key_load = 1'b1;
        bus.subkey_ready = 1'b1;
        @(negedge clk);
        bus.key_load = 1'b0;
        for (int c = 0; c < 40 && !hit; c++) begin
            if (bus.subkey_valid && bus.subkey_rnd == 5'd9) hit = 1;
            else @(negedge clk);
        end
        n_assert++;
        if (!hit) begin
            n_fail++;
            $display("FAIL rstmid_reach: round 9 never seen");
        end
        rst = 1'b1;
        #1;
        n_assert++;
        if ({bus.k56, bus.rnd_sel, bus.subkey, bus.subkey_rnd,
             bus.subkey_valid, bus.key_done, bus.busy} !== '0) begin
            n_fail++;
            $display("FAIL rstmid_clear: got k56=%h rnd=%0d sk=%h skr=%0d v=%b d=%b busy=%b, want all 0",
                     bus.k56, bus.rnd_sel, bus.subkey, bus.subkey_rnd,
                     bus.subkey_valid, bus.key_done, bus.busy);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bus.key_done) dn++;
        end
        n_assert++;
        if (dn !== 0) begin
            n_fail++;
            $display("FAIL rstmid_nodone: got %0d key_done pulses want 0", dn);
        end
        run_sched(KEY_A, 1'b0, 100, -1, 0, 1'b0);
        n_assert++;
        if (xk.size() == 0 || xk[0] !== 48'h1B02EFFC7072 || first_at !== 1) begin
            n_fail++;
            $display("FAIL rstmid_reload: got %0d xfers first at %0d, want round1 1B02EFFC7072 at 1",
                     xk.size(), first_at);
        end
    endtask

    task automatic test_zero_key;
        int bad;
        bad = 0;
        run_sched(64'h0, 1'($urandom_range(0, 1)), 80, -1, 0, 1'b0);
        for (int i = 0; i < xk.size(); i++) if (xk[i] !== 48'h0) bad++;
        n_assert++;
        if (xk.size() != 16 || bad !== 0 || n_done !== 1) begin
            n_fail++;
            $display("FAIL zero_key: got %0d xfers %0d nonzero %0d done want 16 0 1",
                     xk.size(), bad, n_done);
        end
    endtask

    task automatic test_random;
        logic [63:0] key;
        bit dec;
        int r;
        for (int t = 0; t < 5; t++) begin
            key = {$urandom, $urandom};
            dec = 1'($urandom_range(0, 1));
            run_sched(key, dec, 60, -1, 0, 1'b0);
            n_assert++;
            if (k56_seen !== pc1_m(key) || xk.size() != 16 || n_done !== 1 ||
                n_hold !== 0 || t_out) begin
                n_fail++;
                $display("FAIL rnd_run%0d: k56 %h want %h xfers %0d done %0d hold %0d to %b",
                         t, k56_seen, pc1_m(key), xk.size(), n_done, n_hold, t_out);
            end
            for (int i = 0; i < xk.size(); i++) begin
                r = dec ? 16 - i : i + 1;
                n_assert++;
                if (xr[i] !== 5'(r) || xk[i] !== exp_sub(key, r)) begin
                    n_fail++;
                    $display("FAIL rnd_sub%0d[%0d]: got rnd %0d %h want rnd %0d %h",
                             t, i, xr[i], xk[i], r, exp_sub(key, r));
                end
            end
        end
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        bus.key_in = '0;
        bus.key_load = 1'b0;
        bus.decrypt = 1'b0;
        bus.subkey_ready = 1'b0;
        test_reset();
        test_encrypt_vector();
        test_decrypt_vector();
        test_backpressure();
        test_load_ignored();
        test_reset_mid();
        test_zero_key();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
